// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with an AXI-Stream master output.
//
// Deserialises frames made of 1 start bit, 8 data bits sent LSB first and
// 1 stop bit from the asynchronous line i_rxd. Each good byte is held in a
// single-entry output register. Framing errors and overruns are reported
// as one-cycle pulses.
//
// Ports:
//   i_clk            system clock; all logic runs on the rising edge
//   i_rst            synchronous active-high reset
//   i_rxd            asynchronous serial input; idles high
//   o_m_axis_tvalid  received byte valid
//   i_m_axis_tready  downstream accepts the byte
//   o_m_axis_tdata   received byte
//   o_rxd_busy       high whenever the FSM is not in IDLE
//   o_rxd_done       one-cycle pulse for each good frame
//   o_frame_err      one-cycle pulse when the stop bit samples low
//   o_overrun        one-cycle pulse when a good byte is dropped because the
//                    holding register is still full
//
// FSM states:
//   state    | meaning
//   IDLE     | line idle; waiting for a falling edge
//   START    | timing to the middle of the start bit to confirm it
//   RXDATA   | sampling the 8 data bits at mid-bit
//   STOP     | sampling the stop bit at mid-bit
//   BRK_WAIT | framing error seen; waiting for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic       o_m_axis_tvalid,
  input  logic       i_m_axis_tready,
  output logic [7:0] o_m_axis_tdata,
  output logic       o_rxd_busy,
  output logic       o_rxd_done,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_LAST = 8'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    RXDATA   = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } state_t;

  state_t     r_state   = IDLE;
  logic [7:0] r_cnt     = 8'd0;
  logic [2:0] r_bit_idx = 3'd0;
  logic [7:0] r_shift   = 8'd0;
  logic       r_rxd_s1  = 1'b1;
  logic       r_rxd_s2  = 1'b1;
  logic       r_tvalid  = 1'b0;
  logic [7:0] r_tdata   = 8'd0;
  logic       r_done    = 1'b0;
  logic       r_ferr    = 1'b0;
  logic       r_ovr     = 1'b0;

  state_t     s_state;
  logic [7:0] s_cnt;
  logic [2:0] s_bit_idx;
  logic [7:0] s_shift;
  logic       s_tvalid;
  logic [7:0] s_tdata;
  logic       s_done;
  logic       s_ferr;
  logic       s_ovr;
  logic       s_good;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_rxd_s1  <= 1'b1;
      r_rxd_s2  <= 1'b1;
      r_tvalid  <= 1'b0;
      r_tdata   <= 8'd0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= s_state;
      r_cnt     <= s_cnt;
      r_bit_idx <= s_bit_idx;
      r_shift   <= s_shift;
      r_rxd_s1  <= i_rxd;
      r_rxd_s2  <= r_rxd_s1;
      r_tvalid  <= s_tvalid;
      r_tdata   <= s_tdata;
      r_done    <= s_done;
      r_ferr    <= s_ferr;
      r_ovr     <= s_ovr;
    end
  end

  always_comb begin
    s_state   = r_state;
    s_cnt     = r_cnt;
    s_bit_idx = r_bit_idx;
    s_shift   = r_shift;
    s_tvalid  = r_tvalid;
    s_tdata   = r_tdata;
    s_done    = 1'b0;
    s_ferr    = 1'b0;
    s_ovr     = 1'b0;
    s_good    = 1'b0;

    case (r_state)
      IDLE: begin
        s_cnt     = 8'd0;
        s_bit_idx = 3'd0;
        if (!r_rxd_s2) s_state = START;
      end
      START: begin
        if (r_cnt == HALF_LAST) begin
          // Line back high at mid-start means a glitch, not a frame.
          s_cnt   = 8'd0;
          s_state = r_rxd_s2 ? IDLE : RXDATA;
        end else begin
          s_cnt = r_cnt + 8'd1;
        end
      end
      RXDATA: begin
        if (r_cnt == BIT_LAST) begin
          s_cnt              = 8'd0;
          s_shift[r_bit_idx] = r_rxd_s2;
          if (r_bit_idx == 3'd7) begin
            s_bit_idx = 3'd0;
            s_state   = STOP;
          end else begin
            s_bit_idx = r_bit_idx + 3'd1;
          end
        end else begin
          s_cnt = r_cnt + 8'd1;
        end
      end
      STOP: begin
        if (r_cnt == BIT_LAST) begin
          s_cnt = 8'd0;
          // Leaving at mid-stop-bit leaves half a bit to catch the next start.
          if (r_rxd_s2) begin
            s_done  = 1'b1;
            s_good  = 1'b1;
            s_state = IDLE;
          end else begin
            s_ferr  = 1'b1;
            s_state = BRK_WAIT;
          end
        end else begin
          s_cnt = r_cnt + 8'd1;
        end
      end
      BRK_WAIT: begin
        if (r_rxd_s2) s_state = IDLE;
      end
      default: begin
        s_state   = IDLE;
        s_cnt     = 8'd0;
        s_bit_idx = 3'd0;
      end
    endcase

    // Holding register: a load may coincide with the downstream accepting
    // the previous byte; otherwise a full register drops the new byte.
    if (s_good) begin
      if (!r_tvalid || i_m_axis_tready) begin
        s_tvalid = 1'b1;
        s_tdata  = r_shift;
      end else begin
        s_ovr = 1'b1;
      end
    end else if (r_tvalid && i_m_axis_tready) begin
      s_tvalid = 1'b0;
    end
  end

  assign o_m_axis_tvalid = r_tvalid;
  assign o_m_axis_tdata  = r_tdata;
  assign o_rxd_busy      = (r_state != IDLE);
  assign o_rxd_done      = r_done;
  assign o_frame_err     = r_ferr;
  assign o_overrun       = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
//
// A frame-level model predicts, for every transmitted frame, its outcome
// (good byte or framing error) and the nominal completion time, and keeps
// an abstract single-entry holding register driven by the tready values
// the bench applies. A per-cycle compare checks the DUT against it, and
// directed literal checks pin the model at the end of each scenario.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic       i_clk  = 1'b0;
  logic       i_rst  = 1'b1;
  logic       i_rxd  = 1'b1;
  logic       tready = 1'b0;
  logic       tvalid;
  logic [7:0] tdata;
  logic       busy;
  logic       done;
  logic       ferr;
  logic       ovr;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_rxd           (i_rxd),
    .o_m_axis_tvalid (tvalid),
    .i_m_axis_tready (tready),
    .o_m_axis_tdata  (tdata),
    .o_rxd_busy      (busy),
    .o_rxd_done      (done),
    .o_frame_err     (ferr),
    .o_overrun       (ovr)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    bit         good;
    logic [7:0] data;
    int         exp;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] acc[$];

  int checks = 0;
  int errors = 0;

  bit         m_full   = 1'b0;
  logic [7:0] m_data   = 8'd0;
  bit         exp_ovr  = 1'b0;
  bit         rst_q    = 1'b1;
  bit         tready_q = 1'b0;
  int         n_done   = 0;
  int         n_ferr   = 0;
  int         n_ovr    = 0;
  int         last_done_cyc = 0;
  int         t0  = 0;
  int         lat = LAT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit push);
    logic [9:0] f;
    ev_t        e;
    f = {stop, b, 1'b0};
    if (push) begin
      e.good = stop;
      e.data = b;
      e.exp  = cyc + LAT;
      evq.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      i_rxd = f[i];
      wait_cycles(CPB);
    end
  endtask

  // Called once per cycle on the falling edge; tready_q/rst_q hold the values
  // that were present at the rising edge just completed.
  task automatic cmp_cycle();
    ev_t e;
    bit  have;
    bit  hs;
    have = 1'b0;
    if (done || ferr) begin
      if (done) begin
        n_done++;
        last_done_cyc = cyc;
      end
      if (ferr) n_ferr++;
      if (evq.size() == 0) begin
        chk("unexpected_frame_event", 32'd1, 32'd0);
      end else begin
        e    = evq.pop_front();
        have = 1'b1;
        chk("event_done", done, e.good);
        chk("event_ferr", ferr, !e.good);
        chk("event_timing", (cyc >= e.exp - 2) && (cyc <= e.exp + 2), 32'd1);
      end
    end else if (evq.size() != 0 && cyc > evq[0].exp + 2) begin
      e    = evq.pop_front();
      have = 1'b1;
      chk("missing_frame_event", 32'd0, 32'd1);
    end
    if (ovr) n_ovr++;
    exp_ovr = 1'b0;
    if (rst_q) begin
      m_full = 1'b0;
      m_data = 8'd0;
      chk("rst_tvalid", tvalid, 32'd0);
      chk("rst_tdata",  tdata,  32'd0);
      chk("rst_busy",   busy,   32'd0);
      chk("rst_done",   done,   32'd0);
      chk("rst_ferr",   ferr,   32'd0);
      chk("rst_ovr",    ovr,    32'd0);
    end else begin
      hs = m_full && tready_q;
      if (hs) acc.push_back(m_data);
      if (have && e.good) begin
        if (!m_full || tready_q) begin
          m_full = 1'b1;
          m_data = e.data;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (hs) begin
        m_full = 1'b0;
      end
      chk("tvalid", tvalid, m_full);
      if (m_full) chk("tdata", tdata, m_data);
      chk("overrun", ovr, exp_ovr);
    end
    rst_q    = i_rst;
    tready_q = tready;
  endtask

  initial begin
    fork
      forever begin
        @(negedge i_clk);
        cmp_cycle();
      end
    join_none

    i_rst = 1'b1;
    wait_cycles(3);
    i_rst = 1'b0;
    wait_cycles(2);
    chk("reset_tvalid", tvalid, 32'd0);
    chk("reset_tdata",  tdata,  32'd0);
    chk("reset_busy",   busy,   32'd0);

    // Single frame with the downstream always ready.
    tready = 1'b1;
    wait_cycles(5);
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_cycles(20);
    lat = last_done_cyc - t0;
    chk("t1_latency_window", (lat >= LAT - 2) && (lat <= LAT + 2), 32'd1);
    chk("t1_done_count", n_done, 32'd1);
    chk("t1_ferr_count", n_ferr, 32'd0);
    chk("t1_acc_count", acc.size(), 32'd1);
    chk("t1_acc_byte", acc[0], 32'hA5);
    chk("t1_busy_idle", busy, 32'd0);

    // Short low glitch must not start a frame.
    i_rxd = 1'b0;
    wait_cycles(4);
    i_rxd = 1'b1;
    wait_cycles(30);
    chk("t2_busy_idle", busy, 32'd0);
    chk("t2_done_count", n_done, 32'd1);
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_cycles(20);
    chk("t2_acc_count", acc.size(), 32'd2);
    chk("t2_acc_byte", acc[1], 32'h3C);

    // Stop bit low followed by a held break.
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_cycles(40);
    chk("t3_busy_in_break", busy, 32'd1);
    chk("t3_ferr_count", n_ferr, 32'd1);
    chk("t3_done_count", n_done, 32'd2);
    i_rxd = 1'b1;
    wait_cycles(20);
    chk("t3_busy_idle", busy, 32'd0);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_cycles(20);
    chk("t3_acc_count", acc.size(), 32'd3);
    chk("t3_acc_byte", acc[2], 32'h81);

    // Back-to-back frames into a stalled downstream.
    tready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    wait_cycles(20);
    chk("t4_tvalid_held", tvalid, 32'd1);
    chk("t4_tdata_held", tdata, 32'h11);
    chk("t4_ovr_count", n_ovr, 32'd1);
    chk("t4_acc_count_stalled", acc.size(), 32'd3);
    tready = 1'b1;
    wait_cycles(5);
    tready = 1'b0;
    chk("t4_acc_count", acc.size(), 32'd4);
    chk("t4_acc_byte", acc[3], 32'h11);
    chk("t4_tvalid_drained", tvalid, 32'd0);
    wait_cycles(5);

    // Accept of the held byte in the exact cycle the next stop bit is sampled.
    send_frame(8'h11, 1'b1, 1'b1);
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        wait_cycles(lat - 1);
        tready = 1'b1;
        wait_cycles(1);
        tready = 1'b0;
      end
    join
    wait_cycles(20);
    chk("t5_tvalid", tvalid, 32'd1);
    chk("t5_tdata", tdata, 32'h22);
    chk("t5_ovr_count", n_ovr, 32'd1);
    chk("t5_acc_count", acc.size(), 32'd5);
    chk("t5_acc_byte", acc[4], 32'h11);
    tready = 1'b1;
    wait_cycles(5);
    tready = 1'b0;
    chk("t5_acc_count_drain", acc.size(), 32'd6);
    chk("t5_acc_byte_drain", acc[5], 32'h22);

    // Reset pulse in the middle of data bit 4 of 0xF0.
    i_rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      i_rxd = 1'b0;
      wait_cycles(CPB);
    end
    i_rxd = 1'b1;
    wait_cycles(HALF);
    i_rst = 1'b1;
    wait_cycles(1);
    i_rst = 1'b0;
    chk("t6_busy_after_rst", busy, 32'd0);
    chk("t6_tvalid_after_rst", tvalid, 32'd0);
    chk("t6_tdata_after_rst", tdata, 32'd0);
    chk("t6_done_after_rst", done, 32'd0);
    wait_cycles((CPB - HALF - 1) + 4 * CPB + 10);
    chk("t6_busy_idle", busy, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1);
    wait_cycles(20);
    chk("t6_tvalid", tvalid, 32'd1);
    chk("t6_tdata", tdata, 32'h5A);
    tready = 1'b1;
    wait_cycles(5);
    chk("t6_acc_count", acc.size(), 32'd7);
    chk("t6_acc_byte", acc[6], 32'h5A);

    wait_cycles(20);
    chk("all_events_seen", evq.size(), 32'd0);
    chk("final_done_count", n_done, 32'd8);
    chk("final_ferr_count", n_ferr, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the receive-side counterpart of the team's uart_tx. It deserialises 8N1 frames (1 start bit, 8 data bits LSB first, no parity, 1 stop bit) from the asynchronous serial line i_rxd. Each good byte is presented on an AXI-Stream master port with a single-entry holding register. Framing errors and overruns are reported as one-cycle status pulses.

Parameters:
CLKS_PER_BIT, 16, i_clk cycles per UART bit; legal range 4..255; 8-bit counter.

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  reset, synchronous, active-high
i_rxd  input  1  asynchronous serial line; idles high
o_m_axis_tvalid  output  1  received byte valid
i_m_axis_tready  input  1  downstream accepts byte
o_m_axis_tdata  output  8  received byte
o_rxd_busy  output  1  high while a frame is in progress (all states except IDLE)
o_rxd_done  output  1  one-cycle pulse on each good frame
o_frame_err  output  1  one-cycle pulse when the stop bit samples 0
o_overrun  output  1  one-cycle pulse when a good byte is dropped because the holding register is full

Behaviour:
- Reset (i_rst=1 at a clock edge) is synchronous and overrides everything:
  - FSM goes to IDLE; bit index and counter go to 0.
  - Both synchroniser flops (r_rxd_s1, r_rxd_s2) go to 1.
  - o_m_axis_tvalid=0, o_m_axis_tdata=0x00, o_rxd_busy=0, o_rxd_done=0, o_frame_err=0, o_overrun=0.
  - A partially received frame is discarded.
  - The same values apply at power-up through register initialisers.
- Input synchronisation: i_rxd passes through a 2-flop synchroniser. All sampling uses r_rxd_s2 only.
- Timing constant: HALF = CLKS_PER_BIT/2 (integer division).
- IDLE:
  - Counter and bit index are held at 0.
  - r_rxd_s2==0 -> START.
- START:
  - Counter increments each cycle.
  - At count==HALF-1, sample the line:
    - line==0: counter <= 0, go to RXDATA (mid-start-bit alignment).
    - line==1: false start/glitch; go to IDLE with no pulse.
- RXDATA:
  - Counter runs 0..CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1, shift the sample into shift-register bit r_bit_idx and clear the counter.
  - r_bit_idx==7 -> go to STOP with r_bit_idx <= 0; otherwise r_bit_idx increments.
- STOP:
  - At count==CLKS_PER_BIT-1, sample the line:
    - line==1: good frame. Pulse o_rxd_done for 1 cycle, attempt the output load, go to IDLE. Returning at mid-stop-bit allows back-to-back frames.
    - line==0: pulse o_frame_err for 1 cycle, discard the byte, go to BRK_WAIT.
- BRK_WAIT:
  - Stay until r_rxd_s2==1, then go to IDLE.
  - This prevents a break (line held low) from retriggering START.
- Output holding register (AXIS rules):
  - o_m_axis_tvalid, once high, stays high and o_m_axis_tdata stays stable until a cycle with tvalid&&tready.
  - On a good frame: the byte loads and tvalid goes to 1 if tvalid==0, or if tvalid==1 and tready==1 in that same cycle (simultaneous accept and load; tvalid stays 1 with the new data).
  - Good frame while tvalid==1 and tready==0: pulse o_overrun; the old byte is retained and the new byte is dropped. o_rxd_done still pulses.
  - Otherwise, tvalid&&tready -> tvalid <= 0.
  - tready is never used to gate reception.
- Latency: from i_rxd falling edge to the o_rxd_done pulse and tvalid rising = 2 + HALF + 9*CLKS_PER_BIT cycles, ±2 cycles.
- Unused state encodings go to IDLE.

Test Plan:
- CLKS_PER_BIT=16, tready=1; send 0xA5 as 8N1 -> tdata=0xA5, tvalid high for 1 cycle, o_rxd_done pulses once ~154 cycles after the start edge, no error pulses, busy returns to 0.
- i_rxd low for 4 cycles, then high -> no tvalid, no pulses; FSM back in IDLE; the following frame 0x3C is received correctly.
- Send 0x3C with the stop bit forced to 0, line held low 40 cycles, then high -> o_frame_err pulses once, no tvalid/done, no new START until the line is high; next frame 0x81 is received.
- tready=0; send 0x11 then 0x22 back-to-back -> tdata=0x11 held with tvalid=1, o_overrun pulses once at the second stop; raising tready yields 0x11 only.
- tvalid=1 holding 0x11, tready raised in the exact cycle the 0x22 stop bit is sampled -> 0x11 handshakes, 0x22 loads, tvalid stays 1, no overrun.
- Assert i_rst for 1 cycle during data bit 4 of 0xF0 -> all outputs 0 the next cycle, partial byte discarded, next frame 0x5A is received correctly.
